// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - eight-digit multiplexed seven-segment scanner with frame-aligned value update
// Optional leading-zero blanking: define SEG_SCAN_LZB_EN.
module seg_scan #(
    parameter int CLK_DIV   = 100000,
    parameter int BLANK_CYC = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        load,
    input  logic [31:0] din,
    output logic [4:0]  num,
    output logic [7:0]  an,
    output logic        pending,
    output logic        frame_tick
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] TC_VAL    = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] BLANK_VAL = PW'(BLANK_CYC);

    typedef enum logic [1:0] {
        S_OFF,
        S_BLANK,
        S_DRIVE
    } state_t;

    // With no blanking interval every slot starts straight in DRIVE.
    localparam state_t SLOT_START = (BLANK_CYC == 0) ? S_DRIVE : S_BLANK;

    state_t         state, state_d;
    logic [PW-1:0]  presc, presc_d;
    logic [2:0]     idx, idx_d;
    logic [31:0]    active, active_d;
    logic [31:0]    shadow, shadow_d;
    logic           pending_d;
    logic           tc;
    logic           boundary;
    logic [4:0]     num_d;
    logic [7:0]     an_d;

    function automatic logic [4:0] digit_code(input logic [31:0] val, input logic [2:0] k);
        logic [3:0] nib;
        nib = val[{k, 2'b00} +: 4];
`ifdef SEG_SCAN_LZB_EN
        if ((k != 3'd0) && ((val >> {k, 2'b00}) == 32'd0)) begin
            return 5'h10;
        end
`endif
        return {1'b0, nib};
    endfunction

    assign tc       = (presc == TC_VAL);
    assign boundary = (state != S_OFF) && tc && (idx == 3'd7);

    always_comb begin
        state_d = state;
        presc_d = presc;
        idx_d   = idx;
        if (!enable) begin
            state_d = S_OFF;
            presc_d = '0;
            idx_d   = '0;
        end else begin
            case (state)
                S_OFF: begin
                    state_d = SLOT_START;
                    presc_d = '0;
                    idx_d   = '0;
                end
                S_BLANK: begin
                    presc_d = presc + 1'b1;
                    if (presc_d == BLANK_VAL) begin
                        state_d = S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (tc) begin
                        presc_d = '0;
                        idx_d   = idx + 3'd1;
                        state_d = SLOT_START;
                    end else begin
                        presc_d = presc + 1'b1;
                    end
                end
                default: begin
                    state_d = S_OFF;
                    presc_d = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Display value update: immediate when disabled or on the boundary, otherwise parked in shadow.
    always_comb begin
        active_d  = active;
        shadow_d  = shadow;
        pending_d = pending;
        if (!enable || boundary) begin
            if (load) begin
                active_d = din;
                shadow_d = din;
            end else if (pending) begin
                active_d = shadow;
            end
            pending_d = 1'b0;
        end else if (load) begin
            shadow_d  = din;
            pending_d = 1'b1;
        end
    end

    // num tracks the next-cycle index; an is taken from the current state so it lags num by one.
    always_comb begin
        num_d = 5'h10;
        if (state_d != S_OFF) begin
            num_d = digit_code(active_d, idx_d);
        end
        an_d = 8'hFF;
        if (state == S_DRIVE) begin
            an_d = ~(8'b1 << idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_OFF;
            presc      <= '0;
            idx        <= '0;
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
            num        <= 5'h10;
            an         <= 8'hFF;
        end else begin
            state      <= state_d;
            presc      <= presc_d;
            idx        <= idx_d;
            active     <= active_d;
            shadow     <= shadow_d;
            pending    <= pending_d;
            frame_tick <= boundary;
            num        <= num_d;
            an         <= an_d;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - directed self-checking bench for seg_scan (CLK_DIV=4, BLANK_CYC=1)
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [31:0] din;
    logic [4:0]  num;
    logic [7:0]  an;
    logic        pending;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;

    logic [4:0] seq_first [8] = '{5'hF, 5'hE, 5'hD, 5'hC, 5'hB, 5'hA, 5'h9, 5'h8};
`ifdef SEG_SCAN_LZB_EN
    logic [4:0] seq_12 [8] = '{5'h2, 5'h1, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10};
    logic [4:0] zero_slot1 = 5'h10;
`else
    logic [4:0] seq_12 [8] = '{5'h2, 5'h1, 5'h0, 5'h0, 5'h0, 5'h0, 5'h0, 5'h0};
    logic [4:0] zero_slot1 = 5'h0;
`endif

    seg_scan #(
        .CLK_DIV   (4),
        .BLANK_CYC (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .din        (din),
        .num        (num),
        .an         (an),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic adv(input int n);
        repeat (n) tick();
    endtask

    initial begin
        bit ok;
        logic [7:0] exp_an;

        rst    = 1'b1;
        enable = 1'b0;
        load   = 1'b0;
        din    = '0;
        adv(2);
        check("rst_num", num, 5'h10);
        check("rst_an", an, 8'hFF);
        check("rst_pending", pending, 1'b0);
        check("rst_tick", frame_tick, 1'b0);

        rst    = 1'b0;
        enable = 1'b1;
        load   = 1'b1;
        din    = 32'h89ABCDEF;
        tick();
        load = 1'b0;
        din  = '0;
        check("pending_set", pending, 1'b1);

        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            tick();
            if (frame_tick) ok = 1'b1;
            else check("pending_hold", pending, 1'b1);
        end
        check("first_tick_seen", ok, 1'b1);
        check("pending_clear", pending, 1'b0);

        // c = 0 is the cycle frame_tick is high
        for (int c = 0; c < 32; c++) begin
            check("seq_num", num, seq_first[c / 4]);
            if (c == 0) exp_an = 8'h7F;
            else if ((c - 1) % 4 == 0) exp_an = 8'hFF;
            else exp_an = ~(8'b1 << ((c - 1) / 4));
            check("seq_an", an, exp_an);
            check("seq_tick", frame_tick, (c == 0) ? 1'b1 : 1'b0);
            tick();
        end
        check("tick_period", frame_tick, 1'b1);

        adv(31);
        load = 1'b1;
        din  = 32'h00000012;
        tick();
        load = 1'b0;
        din  = '0;
        check("bnd_tick", frame_tick, 1'b1);
        check("bnd_pending", pending, 1'b0);
        check("bnd_num0", num, seq_12[0]);
        tick();
        check("bnd_pending_next", pending, 1'b0);
        adv(3);
        for (int k = 1; k < 8; k++) begin
            check("lzb_num", num, seq_12[k]);
            if (k < 7) adv(4);
        end

        adv(1);
        enable = 1'b0;
        tick();
        check("dis_num", num, 5'h10);
        check("dis_an_lag", an, 8'h7F);
        tick();
        check("dis_an", an, 8'hFF);
        load = 1'b1;
        din  = 32'h00000345;
        tick();
        load = 1'b0;
        din  = '0;
        check("dis_load_pending", pending, 1'b0);
        enable = 1'b1;
        tick();
        check("reen_num", num, 5'h5);
        check("reen_an0", an, 8'hFF);
        tick();
        check("reen_an_blank", an, 8'hFF);
        check("reen_num_hold", num, 5'h5);
        tick();
        check("reen_an_drive", an, 8'hFE);

        load = 1'b1;
        din  = 32'h0000ABCD;
        tick();
        load = 1'b0;
        din  = '0;
        check("mid_pending", pending, 1'b1);
        rst = 1'b1;
        tick();
        check("mrst_num", num, 5'h10);
        check("mrst_an", an, 8'hFF);
        check("mrst_pending", pending, 1'b0);
        check("mrst_tick", frame_tick, 1'b0);
        rst = 1'b0;

        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            tick();
            if (frame_tick) ok = 1'b1;
        end
        check("post_rst_tick_seen", ok, 1'b1);
        check("post_rst_num0", num, 5'h0);
        check("post_rst_pending", pending, 1'b0);
        adv(4);
        check("post_rst_num1", num, zero_slot1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
